// File: rtl/buzz_sched_pkg.sv
// Shared types and limits for the Buzz sharing scheduler.
package buzz_sched_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned MAX_LAT = 8;

  // Tag IDs are sized for the largest supported requester count so one tag type serves every N_REQ.
  localparam int unsigned ID_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, wrapping.
module rr_arbiter import buzz_sched_pkg::*; #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = id_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  logic          found;

  // Scan N positions starting at the pointer; first hit wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr_q) + k) % N);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

  // Pointer moves just past the winner; held when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (32'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/buzz_share_sched.sv
// Shares one Buzz instance among N_REQ requesters: round-robin grant, latency-matched tag pipe,
// and one response slot per requester held until consumed.
module buzz_share_sched import buzz_sched_pkg::*; #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned BUZZ_LAT = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [N_REQ*WIDTH-1:0] resp_data,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]       buzz_I,
  input  logic [WIDTH-1:0]       buzz_O,
  output logic                   busy
);

  localparam int unsigned IW = id_width(N_REQ);

  logic [N_REQ-1:0]       pending_q, pending_d;
  logic [N_REQ-1:0]       resp_valid_q, resp_valid_d;
  logic [N_REQ*WIDTH-1:0] resp_data_q, resp_data_d;
  logic [N_REQ-1:0]       eligible, grant, ret_mask, consume;
  logic [IW-1:0]          grant_idx;
  logic                   grant_any;
  tag_t                   entry_tag, exit_tag;

  // A requester with a request outstanding stays out of arbitration until its slot is consumed,
  // which guarantees its slot is empty when the result returns.
  assign eligible  = req_valid & ~pending_q & {N_REQ{~RESET}};
  assign grant_any = |grant;
  assign req_ready = grant;
  assign consume   = resp_valid_q & resp_ready;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .req_i      (eligible),
    .advance_i  (grant_any),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  // Winner's data drives Buzz; zero when idle.
  always_comb begin
    buzz_I = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) buzz_I = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign entry_tag.vld = grant_any;
  assign entry_tag.id  = ID_W'(grant_idx);

  if (BUZZ_LAT == 0) begin : g_no_pipe
    assign exit_tag = entry_tag;
  end else begin : g_pipe
    tag_t tag_q [BUZZ_LAT];

    // Tag shift register matching Buzz latency.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        for (int unsigned s = 0; s < BUZZ_LAT; s++) tag_q[s] <= '0;
      end else begin
        tag_q[0] <= entry_tag;
        for (int unsigned s = 1; s < BUZZ_LAT; s++) tag_q[s] <= tag_q[s-1];
      end
    end

    assign exit_tag = tag_q[BUZZ_LAT-1];
  end

  // Decode the returning tag into a slot write mask.
  always_comb begin
    ret_mask = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (exit_tag.vld && 32'(exit_tag.id) == i) ret_mask[i] = 1'b1;
    end
  end

  // Consume frees the slot and the requester; grant marks pending; return fills the slot.
  always_comb begin
    pending_d    = (pending_q & ~consume) | grant;
    resp_valid_d = (resp_valid_q & ~consume) | ret_mask;
    resp_data_d  = resp_data_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ret_mask[i]) resp_data_d[i*WIDTH +: WIDTH] = buzz_O;
    end
  end

  // Scheduler state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      pending_q    <= pending_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  // pending covers both in-flight and held-response requesters.
  assign busy       = |{pending_q, resp_valid_q};

  a_grant_onehot0: assert property (@(posedge CLK) disable iff (RESET) $onehot0(req_ready));
  a_no_grant_pending: assert property (@(posedge CLK) disable iff (RESET) (grant & pending_q) == '0);
  a_slot_free: assert property (@(posedge CLK) disable iff (RESET) (ret_mask & resp_valid_q) == '0);

endmodule

// File: tb/tb_buzz_share_sched.sv
// Bench for buzz_share_sched: two instances (N=4/LAT=3 and N=2/LAT=0), Buzz modelled as a delayed
// inverter, per-instance transaction-level model compared every cycle, plus directed scenarios.
module tb_buzz_share_sched;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int             cnt;
    int             id;
    logic [W-1:0]   d;
  } fl_t;

  logic        rst  [2];
  logic [3:0]  rv   [2];
  logic [3:0]  rr   [2];
  logic [15:0] rd   [2];
  logic [3:0]  gnt_o [2];
  logic [3:0]  rvo  [2];
  logic [15:0] rdo  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  for (genvar gv = 0; gv < 2; gv++) begin : g_inst
    localparam int N   = (gv == 0) ? 4 : 2;
    localparam int LAT = (gv == 0) ? 3 : 0;

    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0] req_data, resp_data;
    logic [W-1:0]   buzz_i, buzz_o;
    logic           busy;

    assign req_valid  = rv[gv][N-1:0];
    assign resp_ready = rr[gv][N-1:0];
    assign req_data   = rd[gv][N*W-1:0];
    assign gnt_o[gv]  = 4'(req_ready);
    assign rvo[gv]    = 4'(resp_valid);
    assign rdo[gv]    = 16'(resp_data);

    buzz_share_sched #(
      .N_REQ   (N),
      .WIDTH   (W),
      .BUZZ_LAT(LAT)
    ) u_dut (
      .CLK       (clk),
      .RESET     (rst[gv]),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .resp_valid(resp_valid),
      .resp_data (resp_data),
      .resp_ready(resp_ready),
      .buzz_I    (buzz_i),
      .buzz_O    (buzz_o),
      .busy      (busy)
    );

    // Buzz stand-in: bitwise inverter, LAT cycles late.
    if (LAT == 0) begin : g_b0
      assign buzz_o = ~buzz_i;
    end else begin : g_bd
      logic [W-1:0] line [LAT] = '{default: '0};
      always @(posedge clk) begin
        line[0] <= buzz_i;
        for (int s = 1; s < LAT; s++) line[s] <= line[s-1];
      end
      assign buzz_o = ~line[LAT-1];
    end

    // Model state: pointer, outstanding flags, response slots, in-flight list with countdowns.
    int           ptr = 0;
    logic [N-1:0] pend = '0;
    logic [N-1:0] mrv = '0;
    logic [W-1:0] mrd [N] = '{default: '0};
    fl_t          fl [$];

    function automatic int pick();
      int i;
      if (rst[gv]) return -1;
      for (int k = 0; k < N; k++) begin
        i = (ptr + k) % N;
        if (rv[gv][i] && !pend[i]) return i;
      end
      return -1;
    endfunction

    // Compare this cycle's outputs, then step the model across the coming edge.
    always @(negedge clk) begin : model
      int           gi;
      logic [N*W-1:0] ed;
      fl_t          keep [$];
      keep.delete();
      gi = pick();
      for (int i = 0; i < N; i++) ed[i*W +: W] = mrd[i];
      chk($sformatf("u%0d.req_ready", gv), 32'(req_ready), (gi >= 0) ? (32'd1 << gi) : 32'd0);
      chk($sformatf("u%0d.buzz_I", gv), 32'(buzz_i),
          (gi >= 0) ? 32'(rd[gv][gi*W +: W]) : 32'd0);
      chk($sformatf("u%0d.resp_valid", gv), 32'(resp_valid), 32'(mrv));
      chk($sformatf("u%0d.resp_data", gv), 32'(resp_data), 32'(ed));
      chk($sformatf("u%0d.busy", gv), 32'(busy), 32'(|{pend, mrv}));
      if (rst[gv]) begin
        ptr  = 0;
        pend = '0;
        mrv  = '0;
        for (int i = 0; i < N; i++) mrd[i] = '0;
        fl.delete();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (mrv[i] && rr[gv][i]) begin
            mrv[i]  = 1'b0;
            pend[i] = 1'b0;
          end
        end
        if (gi >= 0) begin
          pend[gi] = 1'b1;
          ptr      = (gi + 1) % N;
          fl.push_back('{LAT, gi, ~rd[gv][gi*W +: W]});
        end
        for (int j = 0; j < fl.size(); j++) begin
          if (fl[j].cnt == 0) begin
            mrv[fl[j].id] = 1'b1;
            mrd[fl[j].id] = fl[j].d;
          end else begin
            fl[j].cnt = fl[j].cnt - 1;
            keep.push_back(fl[j]);
          end
        end
        fl = keep;
      end
    end
  end

  initial begin : main
    int          prev, ng, idx;
    int          cnt [4];
    logic        seen;
    logic [3:0]  prevd;

    for (int j = 0; j < 2; j++) begin
      rst[j] = 1'b1;
      rv[j]  = 4'hF;
      rr[j]  = 4'h0;
      rd[j]  = 16'h0;
    end

    // Reset held with every request valid.
    repeat (2) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        chk("rst_req_ready", 32'(gnt_o[j]), 32'd0);
        chk("rst_resp_valid", 32'(rvo[j]), 32'd0);
      end
    end
    next();

    // Single request on the LAT=3 instance: grant now, response four cycles later, inverted.
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    rv[0]  = 4'b0001;
    rd[0]  = 16'h0001;
    rv[1]  = 4'h0;
    @(negedge clk);
    chk("single_grant", 32'(gnt_o[0]), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      next();
      rv[0] = 4'h0;
      @(negedge clk);
      chk("single_resp_valid", 32'(rvo[0]), (c == 4) ? 32'd1 : 32'd0);
    end
    chk("single_resp_data", 32'(rdo[0]), 32'h000E);
    next();
    rr[0] = 4'hF;
    next();

    // Fairness: all valid, all consumers ready.
    rv[0] = 4'hF;
    prev  = -1;
    ng    = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt_o[0] != 4'h0) begin
        idx = oh2i(gnt_o[0]);
        chk("fair_onehot", 32'($onehot(gnt_o[0])), 32'd1);
        if (prev >= 0) chk("fair_order", 32'(idx), 32'((prev + 1) % 4));
        prev = idx;
        ng++;
      end
      next();
    end
    chk("fair_count", 32'(ng), 32'd16);

    rv[0] = 4'h0;
    repeat (8) next();

    // Backpressure on requester 1.
    rv[0] = 4'hF;
    rr[0] = 4'b1101;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (gnt_o[0][i]) cnt[i]++;
      next();
    end
    chk("bp_req1_once", 32'(cnt[1]), 32'd1);
    chk("bp_req0_rotates", 32'(cnt[0] >= 3), 32'd1);
    chk("bp_req2_rotates", 32'(cnt[2] >= 3), 32'd1);
    chk("bp_req3_rotates", 32'(cnt[3] >= 3), 32'd1);
    rr[0] = 4'hF;
    seen  = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (gnt_o[0][1]) seen = 1'b1;
      next();
    end
    chk("bp_regrant", 32'(seen), 32'd1);

    // Bubble on the LAT=0 instance: grants every other cycle, data inverted.
    rv[0] = 4'h0;
    rv[1] = 4'b0001;
    rr[1] = 4'b0011;
    prevd = 4'h0;
    for (int c = 0; c < 12; c++) begin
      rd[1] = 16'($urandom);
      @(negedge clk);
      chk("bubble_grant", 32'(gnt_o[1]), (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 1) chk("bubble_data", 32'(rdo[1] & 16'h000F), 32'(4'(~prevd)));
      else prevd = rd[1][3:0];
      next();
    end

    // Reset with three tags in flight.
    rv[1] = 4'h0;
    rv[0] = 4'hF;
    rr[0] = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_grant", 32'(gnt_o[0] != 4'h0), 32'd1);
      next();
    end
    rst[0] = 1'b1;
    next();
    rst[0] = 1'b0;
    rv[0]  = 4'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mid_no_resp", 32'(rvo[0]), 32'd0);
      next();
    end
    rv[0] = 4'hF;
    @(negedge clk);
    chk("mid_first_grant", 32'(gnt_o[0]), 32'd1);
    next();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < 2; j++) begin
        rst[j] = ($urandom_range(99) == 0);
        rv[j]  = 4'($urandom);
        rd[j]  = 16'($urandom);
        rr[j]  = 4'($urandom | $urandom);
      end
      next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
